b7_counter: RTL and testbench

//  Free-running two-digit BCD up-counter (00..MODULUS-1) that drives a 2-digit 7-segment display path.
//  The count advances once every DIV clock cycles and wraps to 00 after MODULUS-1.
//  The block is a leaf timing/display source: digits go to downstream BCD-to-7-seg decoders.

---
 rtl/b7_counter_pkg.sv | 19 +
 rtl/b7_counter_digit.sv | 26 ++
 rtl/b7_counter.sv | 64 ++++++
 tb/tb_b7_counter.sv | 111 +++++++++++
 4 files changed

// File: rtl/b7_counter_pkg.sv
// Shared widths, constants and BCD helpers for the two-digit BCD counter.
package b7_counter_pkg;

    localparam int BCD_W   = 4;
    localparam int PRESC_W = 16;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [2*BCD_W-1:0] bcd2_t;

    function automatic bcd2_t to_bcd2(input int v);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(v / 10);
        ones = BCD_W'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/b7_counter_digit.sv
// One BCD digit: counts 0..9 on inc, synchronous clear, carry out at 9.
module bcd_digit
    import b7_counter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    assign co = inc & (q == BCD_MAX);

    // Any code above 9 falls back to 0 on its next increment.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q >= BCD_MAX) ? '0 : q + BCD_W'(1);
        end
    end

endmodule

// File: rtl/b7_counter.sv
// Free-running two-digit BCD up-counter with prescaler and modulus wrap.
module b7_counter
    import b7_counter_pkg::*;
#(
    parameter int MODULUS = 100,
    parameter int DIV     = 1
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [BCD_W-1:0] bcd_0,
    output logic [BCD_W-1:0] bcd_1
);

    if (MODULUS < 2 || MODULUS > 100 || DIV < 1 || DIV > 65536) begin : g_bad_param
        $error("b7_counter: MODULUS must be 2..100 and DIV 1..65536");
    end

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam bcd2_t              WRAP_AT    = to_bcd2(MODULUS - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               wrap;
    logic               roll;
    logic               co_0;
    logic               co_1;
    logic               clr_1;

    // With DIV=1 presc stays at 0, so tick is permanently high.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    assign wrap  = tick & ({bcd_1, bcd_0} == WRAP_AT);
    assign roll  = wrap | co_1;
    assign clr_1 = roll | (tick & (bcd_1 > BCD_MAX));

    bcd_digit u_ones (
        .CLK (CLK),
        .RST (RST),
        .inc (tick),
        .clr (roll),
        .q   (bcd_0),
        .co  (co_0)
    );

    bcd_digit u_tens (
        .CLK (CLK),
        .RST (RST),
        .inc (co_0),
        .clr (clr_1),
        .q   (bcd_1),
        .co  (co_1)
    );

endmodule

// File: tb/tb_b7_counter.sv
// Directed bench for b7_counter: three instances cover MODULUS 100/60 and DIV 1/4.
module tb_b7_counter;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic       rst_c = 1'b0;
    logic [3:0] a0, a1, b0, b1, c0, c1;

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    b7_counter #(.MODULUS(100), .DIV(1)) u_a (
        .CLK(clk), .RST(rst_a), .bcd_0(a0), .bcd_1(a1)
    );
    b7_counter #(.MODULUS(60), .DIV(1)) u_b (
        .CLK(clk), .RST(rst_b), .bcd_0(b0), .bcd_1(b1)
    );
    b7_counter #(.MODULUS(100), .DIV(4)) u_c (
        .CLK(clk), .RST(rst_c), .bcd_0(c0), .bcd_1(c1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int mx;

        // 1: held in reset with clock edges present
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("rst_a", {a1, a0}, 0);
            chk("rst_b", {b1, b0}, 0);
            chk("rst_c", {c1, c0}, 0);
        end

        // 2: MODULUS=100, DIV=1 full cycle
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            edge1();
            chk("a_seq", {a1, a0}, bcd(i % 100));
        end

        // 3: mid-count async reset at 42
        for (int i = 1; i <= 42; i++) edge1();
        chk("a_at42", {a1, a0}, 'h42);
        #4;
        rst_a = 1'b0;
        #1;
        chk("a_async_clr", {a1, a0}, 0);
        for (int i = 0; i < 10; i++) begin
            edge1();
            chk("a_hold_rst", {a1, a0}, 0);
        end
        @(negedge clk);
        rst_a = 1'b1;
        edge1();
        chk("a_first_after_rst", {a1, a0}, 'h01);

        // 6: long run scoreboard, 100 edges = 2000 ns
        n = 1;
        for (int i = 0; i < 100; i++) begin
            edge1();
            n = (n + 1) % 100;
            chk("a_long", {a1, a0}, bcd(n));
            chk("a_dig_ok", int'(a0 <= 4'd9 && a1 <= 4'd9), 1);
        end

        // 4: MODULUS=60 over 200 edges
        @(negedge clk);
        rst_b = 1'b1;
        n  = 0;
        mx = 0;
        for (int i = 0; i < 200; i++) begin
            edge1();
            n = (n + 1) % 60;
            chk("b_seq", {b1, b0}, bcd(n));
            if (int'(b1) * 10 + int'(b0) > mx) mx = int'(b1) * 10 + int'(b0);
        end
        chk("b_max", mx, 59);

        // 5: DIV=4 prescaled counting
        @(negedge clk);
        rst_c = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            edge1();
            chk("c_seq", {c1, c0}, bcd(i / 4));
        end
        chk("c_at40", {c1, c0}, 'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
